hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core. Every cycle it decides the PC write enable, the IF/ID stall and flush, the ID/EX bubble, and the EX/MEM and MEM/WB freeze. It resolves data-memory wait, instruction-memory wait, load-use hazards and taken branches (resolved in ID) by fixed priority. It also keeps stall and flush performance counters and a data-memory wait watchdog.

---
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_if : hazard inputs, pipeline control outputs and perf counters
//                  exchanged between the 5-stage pipeline and hazard_ctrl.
// Revision 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) ();
    logic [REG_W-1:0] IFID_rs1_i;
    logic [REG_W-1:0] IFID_rs2_i;
    logic [REG_W-1:0] IDEX_rd_i;
    logic             IDEX_MemRead_i;
    logic             Branch_taken_i;
    logic             imem_ready_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;
    logic             PCWrite_o;
    logic             IFID_Stall_o;
    logic             IFID_Flush_o;
    logic             IDEX_Bubble_o;
    logic             Freeze_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             wait_err_o;

    // Pipeline side: reports hazards, consumes control decisions
    modport master (
        output IFID_rs1_i, IFID_rs2_i, IDEX_rd_i, IDEX_MemRead_i,
        output Branch_taken_i, imem_ready_i, dmem_req_i, dmem_ready_i,
        input  PCWrite_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o,
        input  stall_cnt_o, flush_cnt_o, wait_err_o
    );

    // Controller side
    modport slave (
        input  IFID_rs1_i, IFID_rs2_i, IDEX_rd_i, IDEX_MemRead_i,
        input  Branch_taken_i, imem_ready_i, dmem_req_i, dmem_ready_i,
        output PCWrite_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o,
        output stall_cnt_o, flush_cnt_o, wait_err_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : fixed-priority pipeline hazard controller with stall/flush
//               counters and a data-memory wait watchdog.
// Revision 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 64
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    hazard_ctrl_if.slave     hz
);
    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);
    localparam logic [7:0] c_wait_sat = 8'hFF;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DWAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_wait_err;

    logic w_dmem_miss;
    logic w_load_use;
    logic w_pc_write;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_freeze;
    logic w_branch_flush;
    logic w_err_set;

    always_comb begin
        w_dmem_miss = hz.dmem_req_i & ~hz.dmem_ready_i;
        w_load_use  = hz.IDEX_MemRead_i & (hz.IDEX_rd_i != REG_W'(0)) &
                      ((hz.IDEX_rd_i == hz.IFID_rs1_i) | (hz.IDEX_rd_i == hz.IFID_rs2_i));
    end

    always_comb begin
        w_pc_write     = 1'b1;
        w_ifid_stall   = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_freeze       = 1'b0;
        w_branch_flush = 1'b0;
        if (rst_i) begin
            w_pc_write   = 1'b0;
            w_ifid_flush = 1'b1;
        end else if (w_dmem_miss) begin
            w_pc_write   = 1'b0;
            w_ifid_stall = 1'b1;
            w_freeze     = 1'b1;
        end else if (w_load_use) begin
            // A branch in ID may depend on the load, so it waits a cycle
            w_pc_write    = 1'b0;
            w_ifid_stall  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (hz.Branch_taken_i) begin
            w_ifid_flush   = 1'b1;
            w_branch_flush = 1'b1;
        end else if (!hz.imem_ready_i) begin
            w_pc_write   = 1'b0;
            w_ifid_flush = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (w_dmem_miss) begin
                    w_state_nxt    = DWAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            DWAIT: begin
                if (w_dmem_miss) begin
                    w_wait_cnt_nxt = (r_wait_cnt == c_wait_sat) ? c_wait_sat
                                                                : r_wait_cnt + 8'd1;
                end else begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
        // The counter holds the number of miss cycles seen so far including
        // this one, so the flag arms on the edge closing the MAX_WAIT-th miss.
        w_err_set = w_dmem_miss & (w_wait_cnt_nxt >= c_max_wait);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_wait_cnt  <= 8'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (!w_pc_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_branch_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (w_err_set) begin
                r_wait_err <= 1'b1;
            end
        end
    end

    assign hz.PCWrite_o     = w_pc_write;
    assign hz.IFID_Stall_o  = w_ifid_stall;
    assign hz.IFID_Flush_o  = w_ifid_flush;
    assign hz.IDEX_Bubble_o = w_idex_bubble;
    assign hz.Freeze_o      = w_freeze;
    assign hz.stall_cnt_o   = r_stall_cnt;
    assign hz.flush_cnt_o   = r_flush_cnt;
    assign hz.wait_err_o    = r_wait_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed vectors with a queued scoreboard for hazard_ctrl.
// Revision 1.0
// ============================================================================
module tb_hazard_ctrl;
    localparam int REG_W    = 5;
    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    // {PCWrite, IFID_Stall, IFID_Flush, IDEX_Bubble, Freeze}
    localparam logic [4:0] c_run  = 5'b10000;
    localparam logic [4:0] c_nop  = 5'b00100;
    localparam logic [4:0] c_lu   = 5'b01010;
    localparam logic [4:0] c_miss = 5'b01001;
    localparam logic [4:0] c_br   = 5'b10100;

    typedef struct {
        int         idx;
        logic [4:0] ctrl;
        int         scnt;
        int         fcnt;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   vec_idx;
    exp_t exp_q[$];
    exp_t m_exp;

    hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    hazard_ctrl #(
        .REG_W    (REG_W),
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input int rs1, input int rs2, input int rd,
                        input logic memrd, input logic br, input logic imem,
                        input logic dreq, input logic drdy,
                        input logic [4:0] ctrl, input int scnt, input int fcnt,
                        input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        rst                  = r;
        hz.IFID_rs1_i        = REG_W'(rs1);
        hz.IFID_rs2_i        = REG_W'(rs2);
        hz.IDEX_rd_i         = REG_W'(rd);
        hz.IDEX_MemRead_i    = memrd;
        hz.Branch_taken_i    = br;
        hz.imem_ready_i      = imem;
        hz.dmem_req_i        = dreq;
        hz.dmem_ready_i      = drdy;
        e.idx  = vec_idx;
        e.ctrl = ctrl;
        e.scnt = scnt;
        e.fcnt = fcnt;
        e.err  = err;
        exp_q.push_back(e);
        vec_idx++;
    endtask

    task automatic idle(input logic [4:0] ctrl, input int scnt, input int fcnt, input logic err);
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ctrl, scnt, fcnt, err);
    endtask

    // Monitor: one DUT response per cycle, compared against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [4:0] act;
            m_exp = exp_q.pop_front();
            act = {hz.PCWrite_o, hz.IFID_Stall_o, hz.IFID_Flush_o, hz.IDEX_Bubble_o, hz.Freeze_o};
            n_checks += 4;
            if (act !== m_exp.ctrl) begin
                n_errors++;
                $display("FAIL ctrl vec%0d: got %b want %b", m_exp.idx, act, m_exp.ctrl);
            end
            if (hz.stall_cnt_o !== CNT_W'(m_exp.scnt)) begin
                n_errors++;
                $display("FAIL stall_cnt vec%0d: got %0d want %0d", m_exp.idx, hz.stall_cnt_o, m_exp.scnt);
            end
            if (hz.flush_cnt_o !== CNT_W'(m_exp.fcnt)) begin
                n_errors++;
                $display("FAIL flush_cnt vec%0d: got %0d want %0d", m_exp.idx, hz.flush_cnt_o, m_exp.fcnt);
            end
            if (hz.wait_err_o !== m_exp.err) begin
                n_errors++;
                $display("FAIL wait_err vec%0d: got %b want %b", m_exp.idx, hz.wait_err_o, m_exp.err);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        vec_idx  = 0;
        rst               = 1'b1;
        hz.IFID_rs1_i     = REG_W'(1);
        hz.IFID_rs2_i     = REG_W'(2);
        hz.IDEX_rd_i      = REG_W'(3);
        hz.IDEX_MemRead_i = 1'b0;
        hz.Branch_taken_i = 1'b0;
        hz.imem_ready_i   = 1'b1;
        hz.dmem_req_i     = 1'b0;
        hz.dmem_ready_i   = 1'b0;
        @(posedge clk);

        // Reset cycle, then idle
        step(1'b1, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c_nop, 0, 0, 1'b0);
        idle(c_run, 0, 0, 1'b0);
        idle(c_run, 0, 0, 1'b0);
        // Load-use on rs2, then rd=0 which never stalls
        step(1'b0, 1, 5, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, c_lu, 0, 0, 1'b0);
        idle(c_run, 1, 0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, c_run, 1, 0, 1'b0);
        // Load-use on rs1 beats a taken branch, branch alone next cycle
        step(1'b0, 7, 2, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, c_lu, 1, 0, 1'b0);
        step(1'b0, 7, 2, 9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, c_br, 2, 0, 1'b0);
        idle(c_run, 2, 1, 1'b0);
        // Three dmem miss cycles, released on the fourth
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c_miss, 2, 1, 1'b0);
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c_miss, 3, 1, 1'b0);
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c_miss, 4, 1, 1'b0);
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, c_run, 5, 1, 1'b0);
        idle(c_run, 5, 1, 1'b0);
        // Six miss cycles: first one also carries load-use and a branch
        step(1'b0, 3, 2, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, c_miss, 5, 1, 1'b0);
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c_miss, 6, 1, 1'b0);
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c_miss, 7, 1, 1'b0);
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c_miss, 8, 1, 1'b0);
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c_miss, 9, 1, 1'b1);
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c_miss, 10, 1, 1'b1);
        // dmem_req drop releases the wait
        idle(c_run, 11, 1, 1'b1);
        idle(c_run, 11, 1, 1'b1);
        step(1'b1, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c_nop, 11, 1, 1'b1);
        idle(c_run, 0, 0, 1'b0);
        // Branch with no fetch data, then fetch wait alone
        step(1'b0, 1, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c_br, 0, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_nop, i, 1, 1'b0);
        end
        // Sixteen stalls into a 4-bit counter: pinned at 15
        step(1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c_nop, 15, 1, 1'b0);
        idle(c_run, 15, 1, 1'b0);
        idle(c_run, 15, 1, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
